// File: rtl/packet_mem_to_avst_if.sv
// Signal bundle between the egress packet reader, its descriptor FIFO, SRAM read port and the
// Avalon-ST sink. PKT_RD_CHANNEL_EN widens the descriptor and adds ochannel.
interface packet_mem_to_avst_if #(
   parameter int unsigned pDATA_WIDTH = 8,
   parameter int unsigned pLEN_WIDTH  = 11,
   parameter int unsigned pADDR_WIDTH = 12
);
`ifdef PKT_RD_CHANNEL_EN
   localparam int unsigned pDESC_WIDTH = 4 + pLEN_WIDTH + pADDR_WIDTH;
`else
   localparam int unsigned pDESC_WIDTH = pLEN_WIDTH + pADDR_WIDTH;
`endif

   logic                   iempty_fifo;
   logic [pDESC_WIDTH-1:0] idesc;
   logic                   ofifo_rd;
   logic [pADDR_WIDTH-1:0] oaddr_r;
   logic [pDATA_WIDTH-1:0] irdata;
   logic                   ovalid;
   logic [pDATA_WIDTH-1:0] odata;
   logic                   ostartofpacket;
   logic                   oendofpacket;
   logic                   iready;
   logic [pADDR_WIDTH-1:0] ord_ptr_succ;
   logic                   ofree;
   logic                   oerr_desc;
`ifdef PKT_RD_CHANNEL_EN
   logic [3:0]             ochannel;
`endif

   modport master (
      input  iempty_fifo, idesc, irdata, iready,
      output ofifo_rd, oaddr_r, ovalid, odata, ostartofpacket, oendofpacket,
`ifdef PKT_RD_CHANNEL_EN
      output ochannel,
`endif
      output ord_ptr_succ, ofree, oerr_desc
   );

   modport slave (
      output iempty_fifo, idesc, irdata, iready,
      input  ofifo_rd, oaddr_r, ovalid, odata, ostartofpacket, oendofpacket,
`ifdef PKT_RD_CHANNEL_EN
      input  ochannel,
`endif
      input  ord_ptr_succ, ofree, oerr_desc
   );
endinterface

// File: rtl/packet_mem_to_avst.sv
// Egress packet reader: pops {len, start_ptr} descriptors and streams SRAM bytes as Avalon-ST.
// Define PKT_RD_CHANNEL_EN to carry a 4-bit channel from the descriptor onto ochannel.
module packet_mem_to_avst #(
   parameter int unsigned pDATA_WIDTH        = 8,
   parameter int unsigned pMAX_PACKET_LENGHT = 1536,
   parameter int unsigned pDEPTH_RAM         = 3072,
   parameter int unsigned pLEN_WIDTH         = $clog2(pMAX_PACKET_LENGHT + 1),
   parameter int unsigned pADDR_WIDTH        = $clog2(pDEPTH_RAM)
) (
   input logic                  iclk,
   input logic                  irst,
   packet_mem_to_avst_if.master bus
);
   localparam logic [pLEN_WIDTH-1:0]  MaxLen    = pLEN_WIDTH'(pMAX_PACKET_LENGHT);
   localparam logic [pLEN_WIDTH-1:0]  LenOne    = pLEN_WIDTH'(1);
   localparam logic [pADDR_WIDTH-1:0] AddrOne   = pADDR_WIDTH'(1);
   localparam logic [pADDR_WIDTH-1:0] LastAddr  = pADDR_WIDTH'(pDEPTH_RAM - 1);
   localparam logic [pADDR_WIDTH:0]   DepthWide = (pADDR_WIDTH + 1)'(pDEPTH_RAM);

   typedef enum logic [1:0] {StIdle, StCheck, StStream, StRelease} state_e;
   state_e state_q, state_d;

   logic [pLEN_WIDTH-1:0]  len_q, rem_q;
   logic [pADDR_WIDTH-1:0] start_q, addr_q, ptr_succ_q;
   logic                   inflight_q, inflight_sop_q, inflight_eop_q;
   logic                   out_v_q, out_sop_q, out_eop_q;
   logic [pDATA_WIDTH-1:0] out_data_q;
   logic                   skid_v_q, skid_sop_q, skid_eop_q;
   logic [pDATA_WIDTH-1:0] skid_data_q;
   logic                   free_q, err_q;
`ifdef PKT_RD_CHANNEL_EN
   logic [3:0]             chan_q;
`endif

   logic                   pop, accept, rd_issue, desc_bad;
   logic [1:0]             occ;
   logic [pADDR_WIDTH:0]   rel_sum, rel_wrap;

   assign desc_bad = (len_q == '0) || (len_q > MaxLen);
   assign accept   = out_v_q && bus.iready;
   assign occ      = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, inflight_q};
   assign rel_sum  = {1'b0, start_q} + (pADDR_WIDTH + 1)'(len_q);
   assign rel_wrap = (rel_sum >= DepthWide) ? rel_sum - DepthWide : rel_sum;

   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      // Only read when the byte is guaranteed a buffer slot on arrival.
      rd_issue = (state_q == StStream) && (rem_q != '0) && ((occ - {1'b0, accept}) < 2'd2);
      case (state_q)
         StIdle: begin
            if (!bus.iempty_fifo) begin
               pop     = 1'b1;
               state_d = StCheck;
            end
         end
         StCheck:   state_d = desc_bad ? StIdle : StStream;
         StStream:  if (accept && out_eop_q) state_d = StRelease;
         StRelease: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge iclk) begin
      if (irst) begin
         state_q        <= StIdle;
         len_q          <= '0;
         rem_q          <= '0;
         start_q        <= '0;
         addr_q         <= '0;
         ptr_succ_q     <= '0;
         inflight_q     <= 1'b0;
         inflight_sop_q <= 1'b0;
         inflight_eop_q <= 1'b0;
         out_v_q        <= 1'b0;
         out_sop_q      <= 1'b0;
         out_eop_q      <= 1'b0;
         out_data_q     <= '0;
         skid_v_q       <= 1'b0;
         skid_sop_q     <= 1'b0;
         skid_eop_q     <= 1'b0;
         skid_data_q    <= '0;
         free_q         <= 1'b0;
         err_q          <= 1'b0;
`ifdef PKT_RD_CHANNEL_EN
         chan_q         <= '0;
`endif
      end else begin
         state_q <= state_d;
         free_q  <= 1'b0;
         err_q   <= 1'b0;

         if (pop) begin
            start_q <= bus.idesc[pADDR_WIDTH-1:0];
            len_q   <= bus.idesc[pLEN_WIDTH+pADDR_WIDTH-1:pADDR_WIDTH];
`ifdef PKT_RD_CHANNEL_EN
            chan_q  <= bus.idesc[pLEN_WIDTH+pADDR_WIDTH +: 4];
`endif
         end

         if (state_q == StCheck) begin
            if (desc_bad) begin
               err_q <= 1'b1;
            end else begin
               addr_q <= start_q;
               rem_q  <= len_q;
            end
         end

         if (rd_issue) begin
            addr_q <= (addr_q == LastAddr) ? '0 : addr_q + AddrOne;
            rem_q  <= rem_q - LenOne;
         end
         inflight_q     <= rd_issue;
         inflight_sop_q <= rd_issue && (rem_q == len_q);
         inflight_eop_q <= rd_issue && (rem_q == LenOne);

         // Output reg is the head; skid only fills when the head is stalled.
         if (accept) begin
            if (skid_v_q) begin
               out_data_q  <= skid_data_q;
               out_sop_q   <= skid_sop_q;
               out_eop_q   <= skid_eop_q;
               skid_v_q    <= inflight_q;
               skid_data_q <= bus.irdata;
               skid_sop_q  <= inflight_sop_q;
               skid_eop_q  <= inflight_eop_q;
            end else begin
               out_v_q    <= inflight_q;
               out_data_q <= bus.irdata;
               out_sop_q  <= inflight_sop_q;
               out_eop_q  <= inflight_eop_q;
            end
         end else if (inflight_q) begin
            if (out_v_q) begin
               skid_v_q    <= 1'b1;
               skid_data_q <= bus.irdata;
               skid_sop_q  <= inflight_sop_q;
               skid_eop_q  <= inflight_eop_q;
            end else begin
               out_v_q    <= 1'b1;
               out_data_q <= bus.irdata;
               out_sop_q  <= inflight_sop_q;
               out_eop_q  <= inflight_eop_q;
            end
         end

         if (state_q == StRelease) begin
            ptr_succ_q <= pADDR_WIDTH'(rel_wrap);
            free_q     <= 1'b1;
         end
      end
   end

   assign bus.ofifo_rd       = pop && !irst;
   assign bus.oaddr_r        = addr_q;
   assign bus.ovalid         = out_v_q;
   assign bus.odata          = out_data_q;
   assign bus.ostartofpacket = out_sop_q;
   assign bus.oendofpacket   = out_eop_q;
   assign bus.ord_ptr_succ   = ptr_succ_q;
   assign bus.ofree          = free_q;
   assign bus.oerr_desc      = err_q;
`ifdef PKT_RD_CHANNEL_EN
   assign bus.ochannel       = chan_q;
`endif
endmodule

// File: tb/tb_packet_mem_to_avst.sv
// Directed bench for packet_mem_to_avst: SRAM model holds addr[7:0] at each address.
// Honours PKT_RD_CHANNEL_EN for the channel field and ochannel checks.
module tb_packet_mem_to_avst;
   localparam int DEPTH = 3072;
`ifdef PKT_RD_CHANNEL_EN
   localparam int DESC_W = 27;
`else
   localparam int DESC_W = 23;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic       sop;
      logic       eop;
      logic [3:0] chan;
      int         cyc;
   } beat_t;

   logic iclk = 1'b0;
   logic irst;

   packet_mem_to_avst_if bus ();
   packet_mem_to_avst dut (.iclk(iclk), .irst(irst), .bus(bus));

   logic [7:0]  sram [0:DEPTH-1];
   beat_t       beats [$];
   logic [11:0] free_ptrs [$];
   int          cyc = 0;
   int          free_cnt = 0, err_cnt = 0, valid_cnt = 0, stall_err = 0, rd_viol = 0;
   logic        stall_q = 1'b0;
   logic [7:0]  st_data;
   logic        st_sop, st_eop;
   logic [3:0]  mon_chan;
   int          checks = 0, errors = 0;
   logic [5:0]  bp_pat = 6'b100101;

`ifdef PKT_RD_CHANNEL_EN
   assign mon_chan = bus.ochannel;
`else
   assign mon_chan = 4'd0;
`endif

   initial forever #5 iclk = ~iclk;
   always @(posedge iclk) cyc <= cyc + 1;
   always @(posedge iclk) bus.irdata <= sram[bus.oaddr_r];

   // Beat collector and stall-stability watcher, sampled on the falling edge.
   always @(negedge iclk) begin
      if (irst) begin
         stall_q <= 1'b0;
      end else begin
         if (stall_q && !(bus.ovalid && bus.odata == st_data &&
                          bus.ostartofpacket == st_sop && bus.oendofpacket == st_eop))
            stall_err <= stall_err + 1;
         if (bus.ovalid && bus.iready)
            beats.push_back('{data: bus.odata, sop: bus.ostartofpacket,
                              eop: bus.oendofpacket, chan: mon_chan, cyc: cyc});
         if (bus.ovalid) valid_cnt <= valid_cnt + 1;
         if (bus.ofree) begin
            free_cnt <= free_cnt + 1;
            free_ptrs.push_back(bus.ord_ptr_succ);
         end
         if (bus.oerr_desc) err_cnt <= err_cnt + 1;
         stall_q <= bus.ovalid && !bus.iready;
         st_data <= bus.odata;
         st_sop  <= bus.ostartofpacket;
         st_eop  <= bus.oendofpacket;
      end
      if (bus.ofifo_rd && bus.iempty_fifo) rd_viol <= rd_viol + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [DESC_W-1:0] make_desc(input int len, input int start, input int chan);
`ifdef PKT_RD_CHANNEL_EN
      make_desc = {chan[3:0], len[10:0], start[11:0]};
`else
      make_desc = {len[10:0], start[11:0]};
      if (chan < 0) make_desc = '0;
`endif
   endfunction

   task automatic issue(input int len, input int start, input int chan, output int pop_cyc);
      int n;
      @(posedge iclk); #1;
      bus.idesc       = make_desc(len, start, chan);
      bus.iempty_fifo = 1'b0;
      n = 0;
      pop_cyc = -1;
      while (pop_cyc < 0 && n < 4000) begin
         @(negedge iclk);
         if (bus.ofifo_rd) pop_cyc = cyc + 1;
         n++;
      end
      @(posedge iclk); #1;
      bus.iempty_fifo = 1'b1;
      check("pop seen", pop_cyc >= 0, 1);
   endtask

   task automatic wait_beats(input int target, input bit bp);
      int n = 0;
      int i = 0;
      while (beats.size() < target && n < 5000) begin
         @(posedge iclk); #1;
         if (bp) begin
            bus.iready = bp_pat[i % 6];
            i++;
         end
         n++;
      end
      bus.iready = 1'b1;
   endtask

   task automatic wait_free(input int target);
      int n = 0;
      while (free_cnt < target && n < 200) begin
         @(posedge iclk); #1;
         n++;
      end
   endtask

   task automatic check_packet(input string tag, input int base, input int len, input int start,
                               input int chan);
      int bad = 0;
      int a;
      for (int i = 0; i < len && base + i < beats.size(); i++) begin
         a = (start + i) % DEPTH;
         if (beats[base+i].data !== a[7:0] || beats[base+i].sop !== (i == 0) ||
             beats[base+i].eop !== (i == len - 1)) bad++;
`ifdef PKT_RD_CHANNEL_EN
         if (beats[base+i].chan !== chan[3:0]) bad++;
`else
         if (chan < 0) bad++;
`endif
      end
      check({tag, " bad beats"}, bad, 0);
   endtask

   initial begin
      int p, p2, b, f, e, v, fp;
      for (int i = 0; i < DEPTH; i++) sram[i] = i[7:0];
      irst            = 1'b1;
      bus.iempty_fifo = 1'b1;
      bus.idesc       = '0;
      bus.iready      = 1'b1;
      repeat (3) @(posedge iclk);
      @(negedge iclk);
      check("rst ovalid", bus.ovalid, 0);
      check("rst sop", bus.ostartofpacket, 0);
      check("rst eop", bus.oendofpacket, 0);
      check("rst odata", bus.odata, 0);
      check("rst oaddr_r", bus.oaddr_r, 0);
      check("rst ptr", bus.ord_ptr_succ, 0);
      check("rst ofree", bus.ofree, 0);
      check("rst oerr", bus.oerr_desc, 0);
      check("rst fifo_rd", bus.ofifo_rd, 0);
`ifdef PKT_RD_CHANNEL_EN
      check("rst chan", bus.ochannel, 0);
`endif
      @(posedge iclk); #1;
      irst = 1'b0;

      // Basic 64-byte packet, full throughput
      b = beats.size(); f = free_cnt;
      issue(64, 0, 3, p);
      wait_beats(b + 64, 1'b0);
      wait_free(f + 1);
      check("t1 beats", beats.size() - b, 64);
      check("t1 latency", beats[b].cyc - p, 3);
      check("t1 streaming", beats[b+63].cyc - beats[b].cyc, 63);
      check_packet("t1", b, 64, 0, 3);
      check("t1 free", free_cnt - f, 1);
      check("t1 ptr", bus.ord_ptr_succ, 64);

      // Address wrap
      b = beats.size(); f = free_cnt;
      issue(64, 3040, 9, p);
      wait_beats(b + 64, 1'b0);
      wait_free(f + 1);
      check("t2 beats", beats.size() - b, 64);
      check_packet("t2", b, 64, 3040, 9);
      check("t2 ptr", bus.ord_ptr_succ, 32);

      // Backpressure
      b = beats.size(); f = free_cnt;
      issue(100, 200, 12, p);
      wait_beats(b + 100, 1'b1);
      wait_free(f + 1);
      check("t3 beats", beats.size() - b, 100);
      check_packet("t3", b, 100, 200, 12);
      check("t3 stable", stall_err, 0);
      check("t3 ptr", bus.ord_ptr_succ, 300);

      // Back-to-back, max length second packet
      b = beats.size(); f = free_cnt; fp = free_ptrs.size();
      issue(64, 0, 1, p);
      issue(1536, 64, 2, p2);
      wait_beats(b + 1600, 1'b0);
      wait_free(f + 2);
      check("t4 beats", beats.size() - b, 1600);
      check_packet("t4a", b, 64, 0, 1);
      check_packet("t4b", b + 64, 1536, 64, 2);
      check("t4 ptr a", free_ptrs[fp], 64);
      check("t4 ptr b", free_ptrs[fp+1], 1600);
      check("t4 sop gap", (beats[b+64].cyc - beats[b+63].cyc) >= 4, 1);

      // Illegal descriptors then single-byte packet
      f = free_cnt; e = err_cnt; v = valid_cnt;
      issue(0, 5, 0, p);
      repeat (8) @(posedge iclk);
      check("t5 len0 err", err_cnt - e, 1);
      issue(1537, 5, 0, p);
      repeat (8) @(posedge iclk);
      check("t5 len1537 err", err_cnt - e, 2);
      check("t5 no valid", valid_cnt - v, 0);
      check("t5 no free", free_cnt - f, 0);
      check("t5 ptr held", bus.ord_ptr_succ, 1600);
      b = beats.size();
      issue(1, 7, 6, p);
      wait_beats(b + 1, 1'b0);
      wait_free(f + 1);
      repeat (4) @(posedge iclk);
      check("t5 one beats", beats.size() - b, 1);
      check_packet("t5 one", b, 1, 7, 6);
      check("t5 one ptr", bus.ord_ptr_succ, 8);

      // Reset at beat 10, then recover
      b = beats.size(); f = free_cnt;
      issue(64, 0, 5, p);
      wait_beats(b + 10, 1'b0);
      irst = 1'b1;
      @(posedge iclk);
      @(negedge iclk);
      check("t6 rst ovalid", bus.ovalid, 0);
      check("t6 rst ptr", bus.ord_ptr_succ, 0);
      check("t6 rst eop", bus.oendofpacket, 0);
      @(posedge iclk); #1;
      irst = 1'b0;
      check("t6 aborted free", free_cnt - f, 0);
      b = beats.size(); f = free_cnt;
      issue(64, 0, 5, p);
      wait_beats(b + 64, 1'b0);
      wait_free(f + 1);
      check("t6 beats", beats.size() - b, 64);
      check_packet("t6", b, 64, 0, 5);
      check("t6 ptr", bus.ord_ptr_succ, 64);

      check("fifo_rd while empty", rd_viol, 0);
      check("stall stability", stall_err, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
